muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 136 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: launches the external multiplier/divider,
// freezes the pipeline until the result lands, and owns the HI/LO registers.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        start_c;
  logic        is_mul, is_div, live;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  // Reset also silences every combinational output, so a divider sharing rst sees no annul.
  assign live   = !rst;

  // NOTE: every signal gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_c = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              state_d = S_MUL;
              cnt_d   = 4'(MUL_LAT);
            end else if (is_div) begin
              if (src2 != 32'd0) begin
                state_d = S_DIV;
                start_c = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else if (op == OP_MTHI) begin
              hi_d = src1;
            end else if (op == OP_MTLO) begin
              lo_d = src1;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            {hi_d, lo_d} = mul_result;
            state_d      = S_DONE;
          end
        end
        S_DIV: begin
          if (div_ready) begin
            hi_d    = div_result[63:32];
            lo_d    = div_result[31:0];
            state_d = S_DONE;
          end else begin
            start_c = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign stallreq   = live && ((state_q == S_IDLE && op_valid && (is_mul || is_div) && !flush)
                               || state_q == S_MUL || state_q == S_DIV);
  assign busy       = busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_signed = live && (op == OP_MULT);
  assign mul_a      = (live && is_mul) ? src1 : 32'd0;
  assign mul_b      = (live && is_mul) ? src2 : 32'd0;
  assign div_start  = live && start_c;
  assign div_signed = live && (op == OP_DIV);
  assign div_op1    = div_start ? src1 : 32'd0;
  assign div_op2    = div_start ? src2 : 32'd0;
  assign div_annul  = live && flush && (state_q == S_DIV);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural multiplier/divider models,
// a table of directed vectors, hand-written flush/reset sequences and random ops.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        flush;
  logic        stallreq, busy;
  logic [31:0] hi, lo;
  logic        mul_signed;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .stallreq(stallreq), .busy(busy), .hi(hi), .lo(lo),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result)
  );

  function automatic logic [63:0] mult_ref(input logic [31:0] a, b, input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // {remainder, quotient}, truncating toward zero for signed operands
  function automatic logic [63:0] div_ref(input logic [31:0] a, b, input logic s);
    int sa, sb;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Architectural effect of one instruction: new HI/LO, stall cycles, div_start cycles.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, b, input int lat,
                                    input logic [31:0] old_hi, old_lo,
                                    output logic [31:0] new_hi, new_lo, output int st, output int ds);
    new_hi = old_hi;
    new_lo = old_lo;
    st = 0;
    ds = 0;
    case (o)
      OP_MULT, OP_MULTU: begin
        {new_hi, new_lo} = mult_ref(a, b, o == OP_MULT);
        st = MUL_LAT + 1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) st = 1;
        else begin
          {new_hi, new_lo} = div_ref(a, b, o == OP_DIV);
          st = lat + 1;
          ds = lat;
        end
      end
      OP_MTHI: new_hi = a;
      OP_MTLO: new_lo = a;
      default: ;
    endcase
  endfunction

  // Fixed-latency multiplier: product of operands seen MUL_LAT edges earlier.
  logic [63:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= mult_ref(mul_a, mul_b, mul_signed);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  // Iterative divider: ready after div_lat cycles of div_start; annul or reset aborts.
  int          div_lat;
  int          dcnt;
  logic        dready;
  logic [63:0] dres;
  logic        force_ready;
  logic [63:0] force_res;
  always @(posedge clk) begin
    if (rst || div_annul) begin
      dcnt   <= 0;
      dready <= 1'b0;
    end else if (div_start) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == div_lat) begin
        dready <= 1'b1;
        dres   <= div_ref(div_op1, div_op2, div_signed);
      end
    end else begin
      dcnt   <= 0;
      dready <= 1'b0;
    end
  end
  assign div_ready  = dready | force_ready;
  assign div_result = force_ready ? force_res : dres;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction and hold it while stalled; report stall and div_start cycle counts
  // plus HI/LO seen in the last (unstalled) cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                        output int stalls, output int dstarts, output logic [31:0] dhi, dlo);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    stalls = 0;
    dstarts = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (div_start) dstarts++;
      if (!stallreq) break;
      stalls++;
      @(negedge clk);
    end
    dhi = hi;
    dlo = lo;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_hi, exp_lo;
    int          exp_stall;
    int          exp_dstart;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] m_hi, m_lo, e_hi, e_lo, d_hi, d_lo, ra, rb;
  logic [2:0]  ro;
  int          st, ds, e_st, e_ds;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_MTHI,  32'h11,       32'h0,        32'h11,       32'h0,        0,  0};
    vecs[1]  = '{OP_MTLO,  32'h22,       32'h0,        32'h11,       32'h22,       0,  0};
    vecs[2]  = '{OP_DIVU,  32'h5,        32'h0,        32'h11,       32'h22,       1,  0};
    vecs[3]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 3,  0};
    vecs[4]  = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 34, 33};
    vecs[5]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE, 3,  0};
    vecs[6]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFE, 0,  0};
    vecs[7]  = '{OP_MTLO,  32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678, 0,  0};
    vecs[8]  = '{3'b110,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h12345678, 0,  0};
    vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 34, 33};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33};

    rst = 1'b1; op_valid = 1'b0; op = 3'b111; src1 = '0; src2 = '0; flush = 1'b0;
    div_lat = 33; force_ready = 1'b0; force_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stallreq", stallreq, 0);
    check("reset busy", busy, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset div_start", div_start, 0);
    check("reset div_annul", div_annul, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, st, ds, d_hi, d_lo);
      check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      check($sformatf("vec%0d stall cycles", i), st, vecs[i].exp_stall);
      check($sformatf("vec%0d div_start cycles", i), ds, vecs[i].exp_dstart);
      if (vecs[i].exp_stall > 0) begin
        check($sformatf("vec%0d hi in DONE", i), d_hi, vecs[i].exp_hi);
        check($sformatf("vec%0d lo in DONE", i), d_lo, vecs[i].exp_lo);
      end
    end
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFFFFFD;

    // Flush in the fifth DIV cycle, then a stray ready that must be ignored.
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; src1 = 32'd100; src2 = 32'd7;
    repeat (4) @(negedge clk);
    #1;
    check("flush pre annul", div_annul, 0);
    check("flush pre div_start", div_start, 1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush annul", div_annul, 1);
    check("flush div_start", div_start, 0);
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush annul width", div_annul, 0);
    check("flush busy", busy, 0);
    check("flush stallreq", stallreq, 0);
    @(negedge clk);
    force_ready = 1'b1; force_res = 64'hAAAABBBB_CCCCDDDD;
    @(negedge clk);
    force_ready = 1'b0;
    #1;
    check("late ready hi", hi, m_hi);
    check("late ready lo", lo, m_lo);
    check("late ready busy", busy, 0);

    // MTLO under flush must not write; MULT under flush in IDLE must not stall or launch.
    @(negedge clk);
    op_valid = 1'b1; op = OP_MTLO; src1 = 32'hCAFEF00D; flush = 1'b1;
    #1;
    check("flushed mtlo stallreq", stallreq, 0);
    @(negedge clk);
    op = OP_MULT; src1 = 32'd9; src2 = 32'd9;
    #1;
    check("flushed mtlo lo", lo, m_lo);
    check("flushed mult stallreq", stallreq, 0);
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    #1;
    check("flushed mult busy", busy, 0);
    check("flushed mult hi", hi, m_hi);

    // Reset during MUL drops the operation.
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; src1 = 32'd5; src2 = 32'd6;
    @(negedge clk);
    #1;
    check("mul busy", busy, 1);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst stallreq", stallreq, 0);
    check("rst busy", busy, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst div_start", div_start, 0);
    check("rst div_annul", div_annul, 0);
    check("rst mul_a", mul_a, 0);
    rst = 1'b0;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, st, ds, d_hi, d_lo);
    check("post-rst multu hi", hi, 32'h1);
    check("post-rst multu lo", lo, 32'hFFFFFFFE);
    check("post-rst multu stall", st, MUL_LAT + 1);
    m_hi = 32'h1;
    m_lo = 32'hFFFFFFFE;

    // Random instruction stream against the reference model.
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (ro == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'd1;
      div_lat = $urandom_range(1, 6);
      ref_model(ro, ra, rb, div_lat, m_hi, m_lo, e_hi, e_lo, e_st, e_ds);
      run_op(ro, ra, rb, st, ds, d_hi, d_lo);
      check($sformatf("rand%0d op%0d hi", n, ro), hi, e_hi);
      check($sformatf("rand%0d op%0d lo", n, ro), lo, e_lo);
      check($sformatf("rand%0d op%0d stall", n, ro), st, e_st);
      check($sformatf("rand%0d op%0d div_start", n, ro), ds, e_ds);
      m_hi = e_hi;
      m_lo = e_lo;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
